// File: rtl/sm83_pkg.sv
// Shared types and opcode classification for the SM83 fetch front end.
// Provides the fetch FSM states, the decoded queue entry and opcode lookups.
package sm83_pkg;

    // Widest program counter any instance may use; entries carry this
    // width and each instance keeps only its own PC_W low bits.
    localparam int PC_W_MAX = 32;

    typedef enum logic [1:0] {
        S_OP,
        S_CB,
        S_IMM_LO,
        S_IMM_HI
    } fetch_state_t;

    // Number of immediate bytes following an opcode: 0, 1 or 2.
    typedef logic [1:0] imm_len_t;

    typedef struct packed {
        logic [7:0]          opcode;
        logic                is_cb;
        logic [15:0]         imm;
        logic [1:0]          len;
        logic [PC_W_MAX-1:0] pc;
        logic                illegal;
    } dec_entry_t;

    function automatic imm_len_t op_imm_len(input logic [7:0] op);
        imm_len_t n;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E,
            8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30,
            8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE,
            8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8,
            8'h10:
                n = 2'd1;
            8'h01, 8'h11, 8'h21, 8'h31,
            8'h08, 8'hC2, 8'hC3, 8'hC4,
            8'hCA, 8'hCC, 8'hCD, 8'hD2,
            8'hD4, 8'hDA, 8'hDC, 8'hEA,
            8'hFA:
                n = 2'd2;
            default:
                n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic op_is_illegal(input logic [7:0] op);
        logic ill;
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3,
            8'hE4, 8'hEB, 8'hEC, 8'hED,
            8'hF4, 8'hFC, 8'hFD:
                ill = 1'b1;
            default:
                ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous clear and an occupancy count.
// Ports: clk/rst_n, clr, push/din, pop/dout (head), count.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= din;
                wptr_q        <= inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/decode_stream.sv
// SM83 byte-stream front end: splits fetched bytes into instructions.
// Ports: flush/flush_pc redirect, in_* byte handshake, out_* queue head.
module decode_stream
    import sm83_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int PC_W      = 16,
    parameter bit ENABLE_CB = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_byte,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_opcode,
    output logic            out_is_cb,
    output logic [15:0]     out_imm,
    output logic [1:0]      out_len,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    localparam int CW = $clog2(OUT_DEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] start_q, start_d;
    logic [7:0]      op_q, op_d;
    logic [7:0]      lo_q, lo_d;
    imm_len_t        need_q, need_d;

    logic            accept;
    logic            pop;
    logic            push;
    logic            op_ill;
    dec_entry_t      push_ent;
    dec_entry_t      head;
    logic [CW-1:0]   count;
    logic            head_unused;

    // Readiness comes only from the registered count, never out_ready.
    assign in_ready  = !flush && (count < CW'(OUT_DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;

    assign op_ill = op_is_illegal(in_byte)
                  || (in_byte == 8'hCB && !ENABLE_CB);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        start_d  = start_q;
        op_d     = op_q;
        lo_d     = lo_q;
        need_d   = need_q;
        push     = 1'b0;
        push_ent = '0;
        if (flush) begin
            state_d = S_OP;
            pc_d    = flush_pc;
        end else if (accept) begin
            pc_d         = pc_q + PC_W'(1);
            push_ent.pc  = PC_W_MAX'(start_q);
            push_ent.len = 2'd1;
            case (state_q)
                S_OP: begin
                    start_d         = pc_q;
                    op_d            = in_byte;
                    need_d          = op_imm_len(in_byte);
                    push_ent.opcode = in_byte;
                    push_ent.pc     = PC_W_MAX'(pc_q);
                    if (in_byte == 8'hCB && ENABLE_CB) begin
                        state_d = S_CB;
                    end else if (op_ill) begin
                        push             = 1'b1;
                        push_ent.illegal = 1'b1;
                    end else if (need_d != 2'd0) begin
                        state_d = S_IMM_LO;
                    end else begin
                        push = 1'b1;
                    end
                end
                S_CB: begin
                    push            = 1'b1;
                    push_ent.opcode = in_byte;
                    push_ent.is_cb  = 1'b1;
                    push_ent.len    = 2'd2;
                    state_d         = S_OP;
                end
                S_IMM_LO: begin
                    lo_d = in_byte;
                    if (need_q == 2'd1) begin
                        push            = 1'b1;
                        push_ent.opcode = op_q;
                        push_ent.imm    = {8'h00, in_byte};
                        push_ent.len    = 2'd2;
                        state_d         = S_OP;
                    end else begin
                        state_d = S_IMM_HI;
                    end
                end
                S_IMM_HI: begin
                    push            = 1'b1;
                    push_ent.opcode = op_q;
                    push_ent.imm    = {in_byte, lo_q};
                    push_ent.len    = 2'd3;
                    state_d         = S_OP;
                end
                default: begin
                    state_d = S_OP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP;
            pc_q    <= '0;
            start_q <= '0;
            op_q    <= '0;
            lo_q    <= '0;
            need_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            start_q <= start_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            need_q  <= need_d;
        end
    end

    sync_fifo #(
        .T     (dec_entry_t),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign out_opcode  = head.opcode;
    assign out_is_cb   = head.is_cb;
    assign out_imm     = head.imm;
    assign out_len     = head.len;
    assign out_pc      = head.pc[PC_W-1:0];
    assign out_illegal = head.illegal;

    // Upper entry PC bits beyond PC_W are always zero.
    assign head_unused = ^head.pc;

endmodule

// File: tb/tb_decode_stream.sv
// Bench for decode_stream: directed literal cases plus a randomized
// stream compared every cycle against an instruction-level model.
module tb_decode_stream;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [7:0]  opcode;
        logic        is_cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flush_pc = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_opcode;
    logic        out_is_cb;
    logic [15:0] out_imm;
    logic [1:0]  out_len;
    logic [15:0] out_pc;
    logic        out_illegal;

    logic        in_valid0 = 1'b0;
    logic        in_ready0;
    logic [7:0]  in_byte0 = '0;
    logic        out_valid0;
    logic        out_ready0 = 1'b0;
    logic [7:0]  out_opcode0;
    logic        out_is_cb0;
    logic [15:0] out_imm0;
    logic [1:0]  out_len0;
    logic [15:0] out_pc0;
    logic        out_illegal0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    decode_stream #(
        .OUT_DEPTH (DEPTH),
        .PC_W      (16),
        .ENABLE_CB (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_is_cb   (out_is_cb),
        .out_imm     (out_imm),
        .out_len     (out_len),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    decode_stream #(
        .OUT_DEPTH (DEPTH),
        .PC_W      (16),
        .ENABLE_CB (1'b0)
    ) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (1'b0),
        .flush_pc    (16'h0000),
        .in_valid    (in_valid0),
        .in_ready    (in_ready0),
        .in_byte     (in_byte0),
        .out_valid   (out_valid0),
        .out_ready   (out_ready0),
        .out_opcode  (out_opcode0),
        .out_is_cb   (out_is_cb0),
        .out_imm     (out_imm0),
        .out_len     (out_len0),
        .out_pc      (out_pc0),
        .out_illegal (out_illegal0)
    );

    task automatic chk(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [7:0] IMM8_L [26] = '{
        8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
        8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
        8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'h10};
    logic [7:0] IMM16_L [17] = '{
        8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4,
        8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA,
        8'hFA};
    logic [7:0] ILL_L [11] = '{
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED,
        8'hF4, 8'hFC, 8'hFD};

    function automatic bit in_list8(input logic [7:0] b);
        foreach (IMM8_L[k]) if (IMM8_L[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_list16(input logic [7:0] b);
        foreach (IMM16_L[k]) if (IMM16_L[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_ill(input logic [7:0] b);
        foreach (ILL_L[k]) if (ILL_L[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Total instruction length implied by its first byte.
    function automatic int total_len(input logic [7:0] b0);
        if (b0 == 8'hCB) return 2;
        if (in_list16(b0)) return 3;
        if (in_list8(b0)) return 2;
        return 1;
    endfunction

    ent_t        mq [8];
    int          mqn = 0;
    logic [7:0]  ib [3];
    int          ibn = 0;
    logic [15:0] mpc = '0;
    logic [15:0] mstart = '0;
    bit          m_acc;

    task automatic model_byte(input logic [7:0] b);
        ent_t e;
        if (ibn == 0) mstart = mpc;
        ib[ibn] = b;
        ibn++;
        mpc = mpc + 16'd1;
        if (ibn == total_len(ib[0])) begin
            e     = '0;
            e.pc  = mstart;
            e.len = 2'(ibn);
            if (ib[0] == 8'hCB) begin
                e.opcode = ib[1];
                e.is_cb  = 1'b1;
            end else begin
                e.opcode = ib[0];
                e.ill    = is_ill(ib[0]);
                if (ibn == 2) e.imm = {8'h00, ib[1]};
                if (ibn == 3) e.imm = {ib[2], ib[1]};
            end
            mq[mqn] = e;
            mqn++;
            ibn = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mqn = 0;
            ibn = 0;
            mpc = '0;
        end else if (flush) begin
            mqn = 0;
            ibn = 0;
            mpc = flush_pc;
        end else begin
            m_acc = in_valid && (mqn < DEPTH);
            if (out_ready && mqn > 0) begin
                for (int k = 0; k < 7; k++) mq[k] = mq[k + 1];
                mqn--;
            end
            if (m_acc) model_byte(in_byte);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready),
                64'(!flush && (mqn < DEPTH)));
            chk("out_valid", 64'(out_valid), 64'(mqn > 0));
            if (mqn > 0 && out_valid) begin
                chk("head", 64'({out_opcode, out_is_cb, out_imm,
                                 out_len, out_pc, out_illegal}),
                    64'(mq[0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] b);
        int  n;
        bit  r;
        n        = 0;
        in_valid = 1'b1;
        in_byte  = b;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'(0), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send0(input logic [7:0] b);
        int  n;
        bit  r;
        n         = 0;
        in_valid0 = 1'b1;
        in_byte0  = b;
        forever begin
            @(negedge clk);
            r = in_ready0;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                chk("send0_timeout", 64'(0), 64'(1));
                break;
            end
        end
        in_valid0 = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_flush(input logic [15:0] p);
        flush    = 1'b1;
        flush_pc = p;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        bit acc;

        // Reset values
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'({out_opcode, out_is_cb, out_imm,
                             out_len, out_pc, out_illegal}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ENABLE_CB=0 build: CB is a lone illegal byte
        send0(8'hCB);
        send0(8'h37);
        chk("cb0_op", 64'(out_opcode0), 64'h00CB);
        chk("cb0_ill", 64'(out_illegal0), 64'(1));
        chk("cb0_len", 64'(out_len0), 64'(1));
        chk("cb0_pc", 64'(out_pc0), 64'h0000);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        chk("n37_op", 64'(out_opcode0), 64'h0037);
        chk("n37_ill", 64'(out_illegal0), 64'(0));
        chk("n37_cb", 64'(out_is_cb0), 64'(0));
        chk("n37_pc", 64'(out_pc0), 64'h0001);
        out_ready0 = 1'b1;

        // 3E 42
        send(8'h3E);
        chk("ld_nv", 64'(out_valid), 64'(0));
        send(8'h42);
        chk("ld_v", 64'(out_valid), 64'(1));
        chk("ld_op", 64'(out_opcode), 64'h3E);
        chk("ld_imm", 64'(out_imm), 64'h0042);
        chk("ld_len", 64'(out_len), 64'(2));
        chk("ld_pc", 64'(out_pc), 64'h0000);
        chk("ld_ill", 64'(out_illegal), 64'(0));
        pop1();
        chk("ld_empty", 64'(out_valid), 64'(0));

        // C3 50 01, CB 37
        do_reset();
        send(8'hC3);
        send(8'h50);
        send(8'h01);
        send(8'hCB);
        send(8'h37);
        chk("jp_op", 64'(out_opcode), 64'hC3);
        chk("jp_imm", 64'(out_imm), 64'h0150);
        chk("jp_len", 64'(out_len), 64'(3));
        chk("jp_pc", 64'(out_pc), 64'h0000);
        pop1();
        chk("cb_op", 64'(out_opcode), 64'h37);
        chk("cb_iscb", 64'(out_is_cb), 64'(1));
        chk("cb_len", 64'(out_len), 64'(2));
        chk("cb_pc", 64'(out_pc), 64'h0003);
        chk("cb_imm", 64'(out_imm), 64'h0000);
        pop1();

        // Backpressure: queue full holds the third byte
        do_reset();
        send(8'h00);
        send(8'h00);
        chk("full_rdy", 64'(in_ready), 64'(0));
        fork
            send(8'h00);
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("held_rdy", 64'(in_ready), 64'(0));
                pop1();
            end
        join
        chk("bp_pc1", 64'(out_pc), 64'h0001);
        pop1();
        chk("bp_pc2", 64'(out_pc), 64'h0002);
        pop1();

        // Flush mid-instruction
        send(8'h01);
        send(8'h34);
        do_flush(16'h0100);
        chk("fl_empty", 64'(out_valid), 64'(0));
        send(8'h00);
        chk("fl_pc", 64'(out_pc), 64'h0100);
        chk("fl_len", 64'(out_len), 64'(1));
        chk("fl_imm", 64'(out_imm), 64'h0000);
        pop1();

        // Illegal opcode
        send(8'hD3);
        chk("ill", 64'(out_illegal), 64'(1));
        chk("ill_len", 64'(out_len), 64'(1));
        pop1();

        // PC wrap
        do_flush(16'hFFFF);
        send(8'h18);
        send(8'hFE);
        send(8'h00);
        chk("wr_pc", 64'(out_pc), 64'hFFFF);
        chk("wr_len", 64'(out_len), 64'(2));
        chk("wr_imm", 64'(out_imm), 64'h00FE);
        pop1();
        chk("wr_pc2", 64'(out_pc), 64'h0001);
        pop1();

        // Asynchronous reset mid-instruction
        send(8'hC3);
        send(8'h50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_rdy", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h00);
        chk("ar_pc", 64'(out_pc), 64'h0000);
        chk("ar_len", 64'(out_len), 64'(1));
        chk("ar_op", 64'(out_opcode), 64'h00);
        pop1();

        // Randomized stream; byte is held while not accepted
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                in_byte  = 8'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(59) == 0);
            flush_pc  = ($urandom_range(7) == 0) ? 16'hFFFE
                                                 : 16'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
